// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter with per-FU hold slots and one branch per cycle.
// Optional stall counters: define CDB_ARB_STATS_EN.
`ifndef N_WAY
`define N_WAY 2
`endif
`ifndef CDB_BITS
`define CDB_BITS 6
`endif
`ifndef XLEN
`define XLEN 32
`endif

module cdb_arbiter #(
   parameter int N_FU  = 4,
   parameter int N_CDB = `N_WAY,
   parameter int TAG_W = `CDB_BITS
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [N_FU-1:0]                  fu_valid,
   input  logic [N_FU-1:0][TAG_W-1:0]       fu_tag,
   input  logic [N_FU-1:0]                  fu_is_branch,
   input  logic [N_FU-1:0]                  fu_take_branch,
   input  logic [N_FU-1:0][`XLEN-1:0]       fu_br_result,
   output logic [N_FU-1:0]                  fu_ready,
   input  logic                             branch_haz,
   output logic [N_CDB-1:0]                 cdb_valid,
   output logic [N_CDB-1:0][TAG_W-1:0]      complete_dest_tag,
   output logic                             take_branch,
`ifdef CDB_ARB_STATS_EN
   output logic [`XLEN-1:0]                 br_result,
   output logic [N_FU-1:0][15:0]            stall_cnt
`else
   output logic [`XLEN-1:0]                 br_result
`endif
);

   localparam int PW = (N_FU > 1) ? $clog2(N_FU) : 1;
   typedef logic [PW-1:0] idx_t;

   logic [N_FU-1:0]                 hold_vld_q, hold_vld_d;
   logic [N_FU-1:0][TAG_W-1:0]      hold_tag_q, hold_tag_d;
   logic [N_FU-1:0]                 hold_br_q, hold_br_d;
   logic [N_FU-1:0]                 hold_tk_q, hold_tk_d;
   logic [N_FU-1:0][`XLEN-1:0]      hold_res_q, hold_res_d;
   idx_t                            rr_q, rr_d;
   logic [N_CDB-1:0]                cdb_vld_q, cdb_vld_d;
   logic [N_CDB-1:0][TAG_W-1:0]     cdb_tag_q, cdb_tag_d;
   logic                            take_q, take_d;
   logic [`XLEN-1:0]                res_q, res_d;
   logic [N_FU-1:0]                 grant;
   int                              lanes;
   int                              s;
   idx_t                            f;
   logic                            br_used;

   // Grants depend only on hold-slot state; a flush suppresses all of them.
   always_comb begin
      grant     = '0;
      rr_d      = rr_q;
      cdb_vld_d = '0;
      cdb_tag_d = '0;
      take_d    = 1'b0;
      res_d     = '0;
      lanes     = 0;
      br_used   = 1'b0;
      s         = 0;
      f         = '0;
      for (int i = 0; i < N_FU; i++) begin
         s = int'(rr_q) + i;
         if (s >= N_FU) s = s - N_FU;
         f = idx_t'(s);
         if (!branch_haz && hold_vld_q[f] && lanes < N_CDB &&
             !(hold_br_q[f] && br_used)) begin
            grant[f] = 1'b1;
            for (int k = 0; k < N_CDB; k++) begin
               if (k == lanes) begin
                  cdb_vld_d[k] = 1'b1;
                  cdb_tag_d[k] = hold_tag_q[f];
               end
            end
            if (hold_br_q[f]) begin
               br_used = 1'b1;
               take_d  = hold_tk_q[f];
               res_d   = hold_res_q[f];
            end
            lanes = lanes + 1;
            rr_d  = (s == N_FU - 1) ? '0 : idx_t'(s + 1);
         end
      end
   end

   always_comb begin
      if (!reset) fu_ready = '0;
      else if (branch_haz) fu_ready = '1;
      else fu_ready = ~hold_vld_q | grant;
   end

   // Zero-tag offers are taken off the FU but never occupy a slot.
   always_comb begin
      hold_vld_d = hold_vld_q;
      hold_tag_d = hold_tag_q;
      hold_br_d  = hold_br_q;
      hold_tk_d  = hold_tk_q;
      hold_res_d = hold_res_q;
      for (int j = 0; j < N_FU; j++) begin
         if (branch_haz) begin
            hold_vld_d[j] = 1'b0;
         end else if (fu_valid[j] && fu_ready[j] && fu_tag[j] != '0) begin
            hold_vld_d[j] = 1'b1;
            hold_tag_d[j] = fu_tag[j];
            hold_br_d[j]  = fu_is_branch[j];
            hold_tk_d[j]  = fu_take_branch[j];
            hold_res_d[j] = fu_br_result[j];
         end else if (grant[j]) begin
            hold_vld_d[j] = 1'b0;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hold_vld_q <= '0;
         hold_tag_q <= '0;
         hold_br_q  <= '0;
         hold_tk_q  <= '0;
         hold_res_q <= '0;
         rr_q       <= '0;
         cdb_vld_q  <= '0;
         cdb_tag_q  <= '0;
         take_q     <= 1'b0;
         res_q      <= '0;
      end else begin
         hold_vld_q <= hold_vld_d;
         hold_tag_q <= hold_tag_d;
         hold_br_q  <= hold_br_d;
         hold_tk_q  <= hold_tk_d;
         hold_res_q <= hold_res_d;
         rr_q       <= rr_d;
         cdb_vld_q  <= cdb_vld_d;
         cdb_tag_q  <= cdb_tag_d;
         take_q     <= take_d;
         res_q      <= res_d;
      end
   end

   assign cdb_valid         = cdb_vld_q;
   assign complete_dest_tag = cdb_tag_q;
   assign take_branch       = take_q;
   assign br_result         = res_q;

`ifdef CDB_ARB_STATS_EN
   logic [N_FU-1:0][15:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      for (int j = 0; j < N_FU; j++) begin
         if (hold_vld_q[j] && !grant[j] && !branch_haz &&
             stall_q[j] != 16'hFFFF)
            stall_d[j] = stall_q[j] + 16'd1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) stall_q <= '0;
      else stall_q <= stall_d;
   end

   assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, reset sequence,
// and randomized traffic against a slot/queue reference model.
`ifndef N_WAY
`define N_WAY 2
`endif
`ifndef CDB_BITS
`define CDB_BITS 6
`endif
`ifndef XLEN
`define XLEN 32
`endif

module tb_cdb_arbiter;
   localparam int NF = 4;
   localparam int NC = `N_WAY;
   localparam int TW = `CDB_BITS;
   localparam int XW = `XLEN;

   logic                     clock = 1'b0;
   logic                     reset;
   logic [NF-1:0]            fu_valid;
   logic [NF-1:0][TW-1:0]    fu_tag;
   logic [NF-1:0]            fu_is_branch;
   logic [NF-1:0]            fu_take_branch;
   logic [NF-1:0][XW-1:0]    fu_br_result;
   logic [NF-1:0]            fu_ready;
   logic                     branch_haz;
   logic [NC-1:0]            cdb_valid;
   logic [NC-1:0][TW-1:0]    complete_dest_tag;
   logic                     take_branch;
   logic [XW-1:0]            br_result;
`ifdef CDB_ARB_STATS_EN
   logic [NF-1:0][15:0]      stall_cnt;
`endif

   cdb_arbiter dut (
      .clock             (clock),
      .reset             (reset),
      .fu_valid          (fu_valid),
      .fu_tag            (fu_tag),
      .fu_is_branch      (fu_is_branch),
      .fu_take_branch    (fu_take_branch),
      .fu_br_result      (fu_br_result),
      .fu_ready          (fu_ready),
      .branch_haz        (branch_haz),
      .cdb_valid         (cdb_valid),
      .complete_dest_tag (complete_dest_tag),
      .take_branch       (take_branch),
`ifdef CDB_ARB_STATS_EN
      .br_result         (br_result),
      .stall_cnt         (stall_cnt)
`else
      .br_result         (br_result)
`endif
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] outs();
      return 128'({cdb_valid, complete_dest_tag, take_branch, br_result});
   endfunction

   typedef struct {
      logic [3:0]          v;
      logic [3:0][TW-1:0]  tag;
      logic [3:0]          br;
      logic [3:0]          tk;
      logic                haz;
      logic [3:0]          rdy;
      logic [1:0]          cv;
      logic [TW-1:0]       t0;
      logic [TW-1:0]       t1;
      logic                etk;
      logic [XW-1:0]       eres;
   } vec_t;

   function automatic vec_t mk(logic [3:0] v, int a, int b, int c, int d,
                               logic [3:0] br, logic [3:0] tk, logic haz,
                               logic [3:0] rdy, logic [1:0] cv, int e0,
                               int e1, logic etk, logic [XW-1:0] eres);
      vec_t r;
      r.v = v;
      r.tag[0] = TW'(a);
      r.tag[1] = TW'(b);
      r.tag[2] = TW'(c);
      r.tag[3] = TW'(d);
      r.br = br;
      r.tk = tk;
      r.haz = haz;
      r.rdy = rdy;
      r.cv = cv;
      r.t0 = TW'(e0);
      r.t1 = TW'(e1);
      r.etk = etk;
      r.eres = eres;
      return r;
   endfunction

   function automatic vec_t idle(logic [3:0] rdy, logic [1:0] cv, int e0,
                                 int e1, logic etk, logic [XW-1:0] eres);
      return mk(4'b0, 0, 0, 0, 0, 4'b0, 4'b0, 1'b0, rdy, cv, e0, e1, etk,
                eres);
   endfunction

   // Reference model state
   logic                m_vld[NF];
   logic [TW-1:0]       m_tag[NF];
   logic                m_br[NF];
   logic                m_tk[NF];
   logic [XW-1:0]       m_res[NF];
   int                  m_rr;
   int                  m_next_rr;
   logic [NF-1:0]       m_g;
   logic [NF-1:0]       m_rdy;
   logic [NC-1:0]       e_cv;
   logic [NC-1:0][TW-1:0] e_tag;
   logic                e_tk;
   logic [XW-1:0]       e_res;

   task automatic model_reset();
      for (int i = 0; i < NF; i++) m_vld[i] = 1'b0;
      m_rr = 0;
   endtask

   task automatic model_arb();
      int order[$];
      int n;
      bit bu;
      m_g = '0;
      e_cv = '0;
      e_tag = '0;
      e_tk = 1'b0;
      e_res = '0;
      m_next_rr = m_rr;
      n = 0;
      bu = 0;
      for (int i = 0; i < NF; i++) order.push_back((m_rr + i) % NF);
      if (!branch_haz) begin
         foreach (order[j]) begin
            int u;
            u = order[j];
            if (m_vld[u] && n < NC && !(m_br[u] && bu)) begin
               m_g[u] = 1'b1;
               e_cv[n] = 1'b1;
               e_tag[n] = m_tag[u];
               n++;
               if (m_br[u]) begin
                  bu = 1;
                  e_tk = m_tk[u];
                  e_res = m_res[u];
               end
               m_next_rr = (u + 1) % NF;
            end
         end
      end
      for (int i = 0; i < NF; i++)
         m_rdy[i] = branch_haz ? 1'b1 : (!m_vld[i] || m_g[i]);
   endtask

   task automatic model_update();
      for (int i = 0; i < NF; i++) begin
         if (branch_haz) m_vld[i] = 1'b0;
         else if (fu_valid[i] && m_rdy[i] && fu_tag[i] != '0) begin
            m_vld[i] = 1'b1;
            m_tag[i] = fu_tag[i];
            m_br[i]  = fu_is_branch[i];
            m_tk[i]  = fu_take_branch[i];
            m_res[i] = fu_br_result[i];
         end else if (m_g[i]) m_vld[i] = 1'b0;
      end
      m_rr = m_next_rr;
   endtask

   task automatic set_idle();
      fu_valid = '0;
      fu_tag = '0;
      fu_is_branch = '0;
      fu_take_branch = '0;
      branch_haz = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[$];

      set_idle();
      for (int i = 0; i < NF; i++) fu_br_result[i] = XW'(32'h100 * (i + 1));
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_ready", 128'(fu_ready), 128'(4'b0000));
      chk("rst_outs", outs(), 128'(0));
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("rel_ready", 128'(fu_ready), 128'(4'b1111));

      // Fill all slots, then drop reset between edges.
      fu_valid = 4'b1111;
      for (int i = 0; i < NF; i++) fu_tag[i] = TW'(i + 1);
      @(posedge clock);
      @(negedge clock);
      set_idle();
      @(posedge clock);
      #1;
      chk("pre_rst_cv", 128'(cdb_valid), 128'(2'b11));
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_outs", outs(), 128'(0));
      chk("mid_rst_ready", 128'(fu_ready), 128'(4'b0000));
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("post_rst_ready", 128'(fu_ready), 128'(4'b1111));
      @(posedge clock);
      #1;
      chk("post_rst_outs", outs(), 128'(0));

      tbl.push_back(mk(4'b0010, 0, 5, 0, 0, 0, 0, 0, 4'b1111, 2'b00, 0, 0, 0, 0));
      tbl.push_back(idle(4'b1111, 2'b01, 5, 0, 0, 0));
      tbl.push_back(idle(4'b1111, 2'b00, 0, 0, 0, 0));
      tbl.push_back(mk(4'b1000, 0, 0, 0, 10, 0, 0, 0, 4'b1111, 2'b00, 0, 0, 0, 0));
      tbl.push_back(idle(4'b1111, 2'b01, 10, 0, 0, 0));
      tbl.push_back(mk(4'b1111, 1, 2, 3, 4, 0, 0, 0, 4'b1111, 2'b00, 0, 0, 0, 0));
      tbl.push_back(idle(4'b0011, 2'b11, 1, 2, 0, 0));
      tbl.push_back(idle(4'b1111, 2'b11, 3, 4, 0, 0));
      tbl.push_back(idle(4'b1111, 2'b00, 0, 0, 0, 0));
      tbl.push_back(mk(4'b0011, 7, 8, 0, 0, 4'b0011, 4'b0001, 0, 4'b1111, 2'b00, 0, 0, 0, 0));
      tbl.push_back(idle(4'b1101, 2'b01, 7, 0, 1, 32'h100));
      tbl.push_back(idle(4'b1111, 2'b01, 8, 0, 0, 32'h200));
      tbl.push_back(idle(4'b1111, 2'b00, 0, 0, 0, 0));
      tbl.push_back(mk(4'b1111, 11, 12, 13, 14, 0, 0, 0, 4'b1111, 2'b00, 0, 0, 0, 0));
      tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 1, 4'b1111, 2'b00, 0, 0, 0, 0));
      tbl.push_back(idle(4'b1111, 2'b00, 0, 0, 0, 0));
      tbl.push_back(mk(4'b0001, 9, 0, 0, 0, 0, 0, 0, 4'b1111, 2'b00, 0, 0, 0, 0));
      tbl.push_back(idle(4'b1111, 2'b01, 9, 0, 0, 0));
      tbl.push_back(mk(4'b0100, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 2'b00, 0, 0, 0, 0));
      tbl.push_back(idle(4'b1111, 2'b00, 0, 0, 0, 0));
      tbl.push_back(mk(4'b0001, 15, 0, 0, 0, 0, 0, 1, 4'b1111, 2'b00, 0, 0, 0, 0));
      tbl.push_back(idle(4'b1111, 2'b00, 0, 0, 0, 0));
      tbl.push_back(mk(4'b0010, 0, 20, 0, 0, 0, 0, 0, 4'b1111, 2'b00, 0, 0, 0, 0));
      tbl.push_back(mk(4'b0010, 0, 21, 0, 0, 0, 0, 0, 4'b1111, 2'b01, 20, 0, 0, 0));
      tbl.push_back(idle(4'b1111, 2'b01, 21, 0, 0, 0));
      tbl.push_back(idle(4'b1111, 2'b00, 0, 0, 0, 0));

      foreach (tbl[r]) begin
         @(negedge clock);
         fu_valid = tbl[r].v;
         fu_tag = tbl[r].tag;
         fu_is_branch = tbl[r].br;
         fu_take_branch = tbl[r].tk;
         branch_haz = tbl[r].haz;
         #1;
         chk($sformatf("vec%0d_ready", r), 128'(fu_ready), 128'(tbl[r].rdy));
         @(posedge clock);
         #1;
         chk($sformatf("vec%0d_outs", r), outs(),
             128'({tbl[r].cv, tbl[r].t1, tbl[r].t0, tbl[r].etk, tbl[r].eres}));
      end

      @(negedge clock);
      set_idle();
      reset = 1'b0;
      #2;
      reset = 1'b1;
      model_reset();

      for (int c = 0; c < 400; c++) begin
         @(negedge clock);
         for (int i = 0; i < NF; i++) begin
            fu_valid[i] = ($urandom_range(0, 99) < 45);
            fu_tag[i] = ($urandom_range(0, 7) == 0) ? '0 :
                        TW'($urandom_range(1, (1 << TW) - 1));
            fu_is_branch[i] = ($urandom_range(0, 2) == 0);
            fu_take_branch[i] = 1'($urandom);
            fu_br_result[i] = XW'($urandom);
         end
         branch_haz = ($urandom_range(0, 15) == 0);
         #1;
         model_arb();
         chk($sformatf("rnd%0d_ready", c), 128'(fu_ready), 128'(m_rdy));
         @(posedge clock);
         #1;
         chk($sformatf("rnd%0d_outs", c), outs(),
             128'({e_cv, e_tag, e_tk, e_res}));
         model_update();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
